// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the odd-parity rule
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } uart_rx_state_e;

    // Parity bit that makes the total number of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [UART_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is configurable
// so idle-high lines do not glitch low out of reset.
module uart_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start 0, 8 data bits MSB-first, optional odd parity, stop 1.
// Define UART_RX_PARITY_EN for 11-bit frames with parity; otherwise frames are 10 bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] read_data_o,
    output logic       read_rdy_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(UART_DATA_BITS);
    // The IDLE detect cycle is the first cycle of the half period, hence HALF-2.
    localparam logic [CntW-1:0] StartCnt = CntW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CntW-1:0] BitCnt   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_sync2 #(
        .ResetVal (1'b1)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rx_i),
        .q_o    (rx_s)
    );

    uart_rx_state_e            state_q;
    logic [CntW-1:0]           cnt_q;
    logic [BitW-1:0]           bit_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [7:0]                data_q;
    logic                      rdy_q;
    logic                      ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                      par_q;
    logic                      perr_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                StStart: begin
                    if (cnt_q == StartCnt) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitCnt) begin
                        cnt_q   <= '0;
                        shift_q <= {shift_q[UART_DATA_BITS-2:0], rx_s};
                        bit_q   <= bit_q + BitW'(1);
                        if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_q == BitCnt) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
`endif
                StStop: begin
                    if (cnt_q == BitCnt) begin
                        cnt_q  <= '0;
                        rdy_q  <= 1'b1;
                        data_q <= shift_q;
                        ferr_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_q <= (par_q != odd_parity(shift_q));
`endif
                        // A low stop bit may be a held line; wait for idle before rearming.
                        state_q <= rx_s ? StIdle : StBreak;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    if (rx_s) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign read_data_o = data_q;
    assign read_rdy_o  = rdy_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame timing, parity/frame errors, glitch rejection,
// back-to-back frames and mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int LAT        = 170;
`else
    localparam int FRAME_BITS = 10;
    localparam int LAT        = 154;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] read_data;
    logic       read_rdy;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int         n_tests;
    int         n_fail;
    int         cyc;
    int         rdy_cnt;
    int         last_rdy_cyc;
    int         prev_rdy_cyc;
    int         p_cyc;
    logic [7:0] data_hist[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_i         (rx),
        .read_data_o  (read_data),
        .read_rdy_o   (read_rdy),
        .parity_err_o (parity_err),
        .frame_err_o  (frame_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rdy_cnt      = 0;
        last_rdy_cyc = -1;
        prev_rdy_cyc = -1;
    end

    always @(negedge clk) begin
        if (read_rdy === 1'b1) begin
            rdy_cnt      = rdy_cnt + 1;
            prev_rdy_cyc = last_rdy_cyc;
            last_rdy_cyc = cyc;
            data_hist.push_back(read_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hold rx at b for one bit period; callers stay aligned 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        p_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) $display("parity bit unused");
`endif
        drive_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", read_data); end
        n_tests++; if (read_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", read_rdy); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        idle_cycles(5);
    endtask

    task automatic test_basic;
        int c0;
        c0 = rdy_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        n_tests++; if (rdy_cnt !== c0 + 1) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", rdy_cnt - c0, 1); end
        n_tests++; if (last_rdy_cyc !== p_cyc + LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", last_rdy_cyc - p_cyc, LAT); end
        n_tests++; if (read_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", read_data); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", parity_err); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", frame_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
        idle_cycles(10);
    endtask

    task automatic test_parity_err;
        int c0;
        logic exp_perr;
`ifdef UART_RX_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        c0 = rdy_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        n_tests++; if (rdy_cnt !== c0 + 1) begin n_fail++; $display("FAIL perr_count: got %0d want 1", rdy_cnt - c0); end
        n_tests++; if (read_data !== 8'h3C) begin n_fail++; $display("FAIL perr_data: got %h want 3c", read_data); end
        n_tests++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL perr_flag: got %b want %b", parity_err, exp_perr); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL perr_ferr: got %b want 0", frame_err); end
        idle_cycles(10);
    endtask

    task automatic test_frame_break;
        int c0;
        c0 = rdy_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_tests++; if (rdy_cnt !== c0 + 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", rdy_cnt - c0); end
        n_tests++; if (read_data !== 8'h81) begin n_fail++; $display("FAIL break_data: got %h want 81", read_data); end
        n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b want 1", frame_err); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL break_perr: got %b want 0", parity_err); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low: got %b want 1", busy); end
        idle_cycles(5);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_release: got %b want 0", busy); end
        idle_cycles(10);
        send_frame(8'h55, 1'b1, 1'b1);
        n_tests++; if (rdy_cnt !== c0 + 2) begin n_fail++; $display("FAIL break_next_count: got %0d want 2", rdy_cnt - c0); end
        n_tests++; if (read_data !== 8'h55) begin n_fail++; $display("FAIL break_next_data: got %h want 55", read_data); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL break_next_ferr: got %b want 0", frame_err); end
        idle_cycles(10);
    endtask

    task automatic test_glitch;
        int c0;
        c0    = rdy_cnt;
        p_cyc = cyc;
        rx    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
        while (cyc < p_cyc + 10) begin
            @(posedge clk);
            #1;
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop: got %b want 0", busy); end
        idle_cycles(200);
        n_tests++; if (rdy_cnt !== c0) begin n_fail++; $display("FAIL glitch_no_strobe: got %0d want 0", rdy_cnt - c0); end
    endtask

    task automatic test_back_to_back;
        int c0;
        int h0;
        c0 = rdy_cnt;
        h0 = data_hist.size();
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'hFE, 1'b0, 1'b1);
        idle_cycles(10);
        n_tests++; if (rdy_cnt !== c0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", rdy_cnt - c0); end
        n_tests++; if (last_rdy_cyc - prev_rdy_cyc !== FRAME_CYC) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", last_rdy_cyc - prev_rdy_cyc, FRAME_CYC); end
        if (data_hist.size() >= h0 + 2) begin
            n_tests++; if (data_hist[h0] !== 8'h12) begin n_fail++; $display("FAIL b2b_first: got %h want 12", data_hist[h0]); end
            n_tests++; if (data_hist[h0+1] !== 8'hFE) begin n_fail++; $display("FAIL b2b_second: got %h want fe", data_hist[h0+1]); end
        end else begin
            n_tests++; n_fail++;
            $display("FAIL b2b_history: got %0d bytes want 2", data_hist.size() - h0);
        end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL b2b_perr: got %b want 0", parity_err); end
    endtask

    task automatic test_reset_mid;
        int c0;
        logic [7:0] d;
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 7; i >= 4; i--) drive_bit(d[i]);
        rx = d[3];
        repeat (CPB / 2) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        c0    = rdy_cnt;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_tests++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h want 00", read_data); end
        n_tests++; if (frame_err !== 1'b0 || parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b%b want 00", frame_err, parity_err); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(200);
        n_tests++; if (rdy_cnt !== c0) begin n_fail++; $display("FAIL rst_mid_no_strobe: got %0d want 0", rdy_cnt - c0); end
        send_frame(8'h0F, 1'b1, 1'b1);
        n_tests++; if (rdy_cnt !== c0 + 1) begin n_fail++; $display("FAIL rst_mid_next_count: got %0d want 1", rdy_cnt - c0); end
        n_tests++; if (last_rdy_cyc !== p_cyc + LAT) begin n_fail++; $display("FAIL rst_mid_next_latency: got %0d want %0d", last_rdy_cyc - p_cyc, LAT); end
        n_tests++; if (read_data !== 8'h0F) begin n_fail++; $display("FAIL rst_mid_next_data: got %h want 0f", read_data); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_next_perr: got %b want 0", parity_err); end
        idle_cycles(10);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rx      = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_parity_err();
        test_frame_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
